// File: rtl/jelly_bean_tasting_master.sv
// ---------------------------------------------------------------------------
// jelly_bean_types: shared bus encodings for the jelly bean bus.
//
// jelly_bean_tasting_master: bus initiator for the jelly bean taster.
//   It takes one order at a time on a valid/ready request port. For each
//   order it drives a WRITE cycle, then READ_LATENCY-1 NO_OP wait cycles,
//   then a READ cycle, and captures the taster's taste. The result is
//   returned on a valid/ready response port. Saturating YUMMY/YUCKY tallies
//   count the delivered results.
//
// Ports
//   clk, rst_n                  bus clock, asynchronous active-low reset
//   req_valid/req_ready         order handshake
//   req_flavor/color/sugar_free/sour   order fields
//   rsp_valid/rsp_ready         result handshake
//   rsp_taste, rsp_flavor       captured taste and the flavour of its order
//   flavor/color/sugar_free/sour/command   bus outputs to the taster
//   taste                       bus taste from the taster
//   yummy_cnt, yucky_cnt        saturating tallies of delivered results
//   busy                        master is not idle
// ---------------------------------------------------------------------------
package jelly_bean_types;
    typedef enum logic [2:0] {
        NO_FLAVOR  = 3'd0,
        APPLE      = 3'd1,
        BLUEBERRY  = 3'd2,
        BUBBLE_GUM = 3'd3,
        CHOCOLATE  = 3'd4
    } flavor_e;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } color_e;

    typedef enum logic [1:0] {
        NO_OP = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } command_e;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        YUMMY   = 2'd1,
        YUCKY   = 2'd2
    } taste_e;
endpackage

module jelly_bean_tasting_master
    import jelly_bean_types::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // order request
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_flavor,
    input  logic [1:0]       req_color,
    input  logic             req_sugar_free,
    input  logic             req_sour,
    // tasting response
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_taste,
    output logic [2:0]       rsp_flavor,
    // jelly bean bus
    output logic [2:0]       flavor,
    output logic [1:0]       color,
    output logic             sugar_free,
    output logic             sour,
    output logic [1:0]       command,
    input  logic [1:0]       taste,
    // status
    output logic [CNT_W-1:0] yummy_cnt,
    output logic [CNT_W-1:0] yucky_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT,
        S_READ,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [2:0] flavor;
        logic [1:0] color;
        logic       sugar_free;
        logic       sour;
    } order_t;

    // WAIT lasts READ_LATENCY-1 cycles; the counter runs 0 .. READ_LATENCY-2.
    localparam int unsigned WAIT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam int unsigned WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e              state, state_nxt;
    order_t              order_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                accept;
    logic                rsp_hs;
    logic                bus_active;

    assign accept    = req_valid && (state == S_IDLE);
    assign rsp_hs    = rsp_ready && (state == S_RESP);
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and bus outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        bus_active = 1'b0;
        command    = NO_OP;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    // NO_FLAVOR orders never touch the bus
                    state_nxt = (req_flavor != NO_FLAVOR) ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: begin
                bus_active = 1'b1;
                command    = WRITE;
                state_nxt  = (READ_LATENCY > 1) ? S_WAIT : S_READ;
            end
            S_WAIT: begin
                bus_active = 1'b1;
                if (wait_cnt == WAIT_W'(WAIT_LAST)) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                bus_active = 1'b1;
                command    = READ;
                state_nxt  = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outside an access the bus rests at NO_OP/NO_FLAVOR so the taster holds.
    assign flavor     = bus_active ? order_q.flavor     : NO_FLAVOR;
    assign color      = bus_active ? order_q.color      : 2'd0;
    assign sugar_free = bus_active ? order_q.sugar_free : 1'b0;
    assign sour       = bus_active ? order_q.sour       : 1'b0;

    // -----------------------------------------------------------------------
    // Wait-cycle counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Order latch and response capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_q    <= '0;
            rsp_taste  <= UNKNOWN;
            rsp_flavor <= '0;
        end else begin
            if (accept) begin
                order_q    <= '{flavor:     req_flavor,
                                color:      req_color,
                                sugar_free: req_sugar_free,
                                sour:       req_sour};
                rsp_flavor <= req_flavor;
                if (req_flavor == NO_FLAVOR) begin
                    rsp_taste <= UNKNOWN;
                end
            end
            // taste is sampled at the edge that closes the READ cycle
            if (state == S_READ) begin
                rsp_taste <= taste;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Saturating tallies, counted only on a delivered response
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yummy_cnt <= '0;
            yucky_cnt <= '0;
        end else if (rsp_hs) begin
            if (rsp_taste == YUMMY && yummy_cnt != CNT_MAX) begin
                yummy_cnt <= yummy_cnt + CNT_W'(1);
            end
            if (rsp_taste == YUCKY && yucky_cnt != CNT_MAX) begin
                yucky_cnt <= yucky_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_jelly_bean_tasting_master.sv
// ---------------------------------------------------------------------------
// Bench for jelly_bean_tasting_master. Two instances: index 0 has
// READ_LATENCY=1, CNT_W=2 (saturation); index 1 has READ_LATENCY=3,
// CNT_W=16. The taster model drives the planned taste only during READ and
// the complement otherwise, so a mistimed capture shows up.
// ---------------------------------------------------------------------------
module tb_jelly_bean_tasting_master;

    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;
    localparam logic [1:0] UNK = 2'd0, YUM = 2'd1, YUK = 2'd2;
    localparam logic [2:0] F_NONE = 3'd0, F_APPLE = 3'd1, F_CHOC = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid [2];
    logic       req_ready [2];
    logic [2:0] req_flavor [2];
    logic [1:0] req_color [2];
    logic       req_sugar_free [2];
    logic       req_sour [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [1:0] rsp_taste [2];
    logic [2:0] rsp_flavor [2];
    logic [2:0] flavor [2];
    logic [1:0] color [2];
    logic       sugar_free [2];
    logic       sour [2];
    logic [1:0] command [2];
    logic [1:0] taste [2];
    logic       busy [2];
    logic [1:0]  y0, u0;
    logic [15:0] y1, u1;
    logic [1:0] plan_taste [2];

    int tests  = 0;
    int failed = 0;
    int lat [2]     = '{1, 3};
    int cnt_max [2] = '{3, 65535};
    int exp_y [2]   = '{0, 0};
    int exp_u [2]   = '{0, 0};

    always #5 clk = ~clk;

    assign taste[0] = (command[0] == RD) ? plan_taste[0] : ~plan_taste[0];
    assign taste[1] = (command[1] == RD) ? plan_taste[1] : ~plan_taste[1];

    jelly_bean_tasting_master #(.READ_LATENCY(1), .CNT_W(2)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_flavor(req_flavor[0]), .req_color(req_color[0]),
        .req_sugar_free(req_sugar_free[0]), .req_sour(req_sour[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_taste(rsp_taste[0]), .rsp_flavor(rsp_flavor[0]),
        .flavor(flavor[0]), .color(color[0]), .sugar_free(sugar_free[0]),
        .sour(sour[0]), .command(command[0]), .taste(taste[0]),
        .yummy_cnt(y0), .yucky_cnt(u0), .busy(busy[0])
    );

    jelly_bean_tasting_master #(.READ_LATENCY(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_flavor(req_flavor[1]), .req_color(req_color[1]),
        .req_sugar_free(req_sugar_free[1]), .req_sour(req_sour[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_taste(rsp_taste[1]), .rsp_flavor(rsp_flavor[1]),
        .flavor(flavor[1]), .color(color[1]), .sugar_free(sugar_free[1]),
        .sour(sour[1]), .command(command[1]), .taste(taste[1]),
        .yummy_cnt(y1), .yucky_cnt(u1), .busy(busy[1])
    );

    function automatic logic [15:0] get_y(input int d);
        return (d == 0) ? {14'd0, y0} : y1;
    endfunction

    function automatic logic [15:0] get_u(input int d);
        return (d == 0) ? {14'd0, u0} : u1;
    endfunction

    // Offer an order (caller is at a negedge) and wait for it to be taken.
    task automatic accept(input int d, input logic [2:0] f, input logic [1:0] c,
                          input logic sf, input logic so);
        int n = 0;
        req_flavor[d] = f; req_color[d] = c;
        req_sugar_free[d] = sf; req_sour[d] = so;
        req_valid[d] = 1'b1;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (req_ready[d] !== 1'b1) begin
            failed++;
            $display("FAIL accept_timeout d=%0d req_ready=%b want 1", d, req_ready[d]);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    // Walk the order through the bus and response phases, checking every
    // cycle against the expected trace; hold rsp_ready low for 'delay' cycles.
    task automatic complete(input int d, input logic [2:0] f, input logic [1:0] c,
                            input logic sf, input logic so, input logic [1:0] tst,
                            input int delay);
        logic [1:0] exp_t;
        logic [1:0] exp_cmd;
        int n_act;
        exp_t = (f == F_NONE) ? UNK : tst;
        n_act = (f == F_NONE) ? 0 : lat[d] + 1;
        plan_taste[d] = tst;
        rsp_ready[d] = (delay == 0);
        for (int cyc = 1; cyc <= n_act; cyc++) begin
            exp_cmd = (cyc == 1) ? WR : ((cyc == n_act) ? RD : NOP);
            tests++;
            if ({command[d], flavor[d], color[d], sugar_free[d], sour[d], rsp_valid[d]}
                !== {exp_cmd, f, c, sf, so, 1'b0}) begin
                failed++;
                $display("FAIL bus_cycle d=%0d cyc=%0d got cmd=%0d fl=%0d col=%0d sf=%b so=%b rv=%b want cmd=%0d fl=%0d col=%0d sf=%b so=%b rv=0",
                         d, cyc, command[d], flavor[d], color[d], sugar_free[d], sour[d],
                         rsp_valid[d], exp_cmd, f, c, sf, so);
            end
            @(negedge clk);
        end
        tests++;
        if ({rsp_valid[d], rsp_taste[d], rsp_flavor[d], req_ready[d], busy[d]}
            !== {1'b1, exp_t, f, 1'b0, 1'b1}) begin
            failed++;
            $display("FAIL rsp_first d=%0d got rv=%b taste=%0d fl=%0d rr=%b busy=%b want rv=1 taste=%0d fl=%0d rr=0 busy=1",
                     d, rsp_valid[d], rsp_taste[d], rsp_flavor[d], req_ready[d], busy[d], exp_t, f);
        end
        tests++;
        if ({command[d], flavor[d], color[d], sugar_free[d], sour[d]} !== 9'd0) begin
            failed++;
            $display("FAIL bus_idle_resp d=%0d got cmd=%0d fl=%0d want NO_OP/NO_FLAVOR",
                     d, command[d], flavor[d]);
        end
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            tests++;
            if ({rsp_valid[d], rsp_taste[d], rsp_flavor[d], req_ready[d]}
                !== {1'b1, exp_t, f, 1'b0}) begin
                failed++;
                $display("FAIL rsp_hold d=%0d k=%0d got rv=%b taste=%0d fl=%0d rr=%b want rv=1 taste=%0d fl=%0d rr=0",
                         d, k, rsp_valid[d], rsp_taste[d], rsp_flavor[d], req_ready[d], exp_t, f);
            end
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        if (exp_t == YUM && exp_y[d] < cnt_max[d]) exp_y[d]++;
        if (exp_t == YUK && exp_u[d] < cnt_max[d]) exp_u[d]++;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        tests++;
        if ({rsp_valid[d], req_ready[d], busy[d], command[d]} !== {1'b0, 1'b1, 1'b0, NOP}) begin
            failed++;
            $display("FAIL after_hs d=%0d got rv=%b rr=%b busy=%b cmd=%0d want rv=0 rr=1 busy=0 cmd=0",
                     d, rsp_valid[d], req_ready[d], busy[d], command[d]);
        end
        tests++;
        if (get_y(d) !== 16'(exp_y[d]) || get_u(d) !== 16'(exp_u[d])) begin
            failed++;
            $display("FAIL tally d=%0d got yummy=%0d yucky=%0d want yummy=%0d yucky=%0d",
                     d, get_y(d), get_u(d), exp_y[d], exp_u[d]);
        end
    endtask

    task automatic check_idle(input string name);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({command[d], flavor[d], color[d], sugar_free[d], sour[d], rsp_valid[d],
                 req_ready[d], busy[d], get_y(d), get_u(d)}
                !== {9'd0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0}) begin
                failed++;
                $display("FAIL %s d=%0d got cmd=%0d fl=%0d rv=%b rr=%b busy=%b y=%0d u=%0d want idle and zero",
                         name, d, command[d], flavor[d], rsp_valid[d], req_ready[d], busy[d],
                         get_y(d), get_u(d));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_y = '{0, 0};
        exp_u = '{0, 0};
        #1;
        check_idle("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_idle("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // build up a nonzero tally, then abort an order in the middle of WAIT
        accept(1, F_APPLE, 2'd1, 1'b0, 1'b0);
        complete(1, F_APPLE, 2'd1, 1'b0, 1'b0, YUM, 0);
        accept(1, 3'd2, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_y = '{0, 0};
        exp_u = '{0, 0};
        #1;
        check_idle("reset_mid_wait");
        @(negedge clk);
        check_idle("reset_held");
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests++;
            if ({rsp_valid[1], command[1], busy[1]} !== {1'b0, NOP, 1'b0}) begin
                failed++;
                $display("FAIL abort_no_rsp k=%0d got rv=%b cmd=%0d busy=%b want 0/0/0",
                         k, rsp_valid[1], command[1], busy[1]);
            end
        end
    endtask

    task automatic test_write_read_l1();
        accept(0, F_CHOC, 2'd2, 1'b0, 1'b1);
        complete(0, F_CHOC, 2'd2, 1'b0, 1'b1, YUK, 0);
    endtask

    task automatic test_wait_l3();
        accept(1, F_APPLE, 2'd0, 1'b1, 1'b0);
        complete(1, F_APPLE, 2'd0, 1'b1, 1'b0, YUM, 0);
    endtask

    task automatic test_no_flavor();
        accept(0, F_NONE, 2'd3, 1'b1, 1'b1);
        complete(0, F_NONE, 2'd3, 1'b1, 1'b1, YUM, 0);
        accept(1, F_NONE, 2'd1, 1'b0, 1'b1);
        complete(1, F_NONE, 2'd1, 1'b0, 1'b1, YUK, 1);
    endtask

    task automatic test_back_to_back();
        accept(1, F_CHOC, 2'd1, 1'b1, 1'b1);
        // next order is offered during the whole first order, including RESP
        req_flavor[1] = F_APPLE; req_color[1] = 2'd2;
        req_sugar_free[1] = 1'b0; req_sour[1] = 1'b1;
        req_valid[1] = 1'b1;
        complete(1, F_CHOC, 2'd1, 1'b1, 1'b1, YUK, 5);
        accept(1, F_APPLE, 2'd2, 1'b0, 1'b1);
        complete(1, F_APPLE, 2'd2, 1'b0, 1'b1, YUM, 0);
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            accept(0, F_APPLE, 2'd0, 1'b0, 1'b0);
            complete(0, F_APPLE, 2'd0, 1'b0, 1'b0, YUM, 0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int d;
            logic [2:0] f;
            logic [1:0] c, t;
            logic sf, so;
            d  = int'($urandom_range(0, 1));
            f  = ($urandom_range(0, 4) == 0) ? F_NONE : 3'($urandom_range(1, 7));
            c  = 2'($urandom_range(0, 3));
            t  = 2'($urandom_range(0, 3));
            sf = 1'($urandom_range(0, 1));
            so = 1'($urandom_range(0, 1));
            accept(d, f, c, sf, so);
            complete(d, f, c, sf, so, t, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_flavor[d] = '0; req_color[d] = '0;
            req_sugar_free[d] = 1'b0; req_sour[d] = 1'b0;
            rsp_ready[d] = 1'b0; plan_taste[d] = UNK;
        end
        test_reset();
        test_write_read_l1();
        test_wait_l3();
        test_no_flavor();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
